// File: rtl/fmv_pixel_pacer.sv
// rtl/fmv_pixel_pacer.sv - pixel FIFO with per-line crop and newpixel-paced output; optional stats: FMV_PIXEL_PACER_STATS_EN
module fmv_pixel_pacer #(
  parameter int DEPTH = 8,
  parameter int PIXW  = 24
) (
  input  logic            clk30,
  input  logic            reset_n,
  input  logic            newpixel,
  input  logic            line_start,
  input  logic            in_valid,
  input  logic [PIXW-1:0] in_data,
  output logic            in_ready,
  input  logic [9:0]      crop_left,
  input  logic [9:0]      width,
  output logic            out_valid,
  output logic [PIXW-1:0] out_pixel,
  output logic            line_active,
  output logic            underflow,
  output logic [15:0]     underflow_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SKIP   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t          state_q, state_d;

  // FIFO storage and pointers (extra MSB distinguishes full from empty)
  logic [PIXW-1:0] mem_q [DEPTH];
  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;
  logic            fifo_empty;
  logic            fifo_full;
  logic            push;
  logic            pop;
  logic [PIXW-1:0] head_data;

  // Per-line latched geometry and progress counters
  logic [9:0]      crop_q, crop_d;
  logic [9:0]      width_q, width_d;
  logic [9:0]      skip_cnt_q, skip_cnt_d;
  logic [9:0]      out_cnt_q, out_cnt_d;

  // Output registers
  logic            out_valid_q, out_valid_d;
  logic [PIXW-1:0] out_pixel_q, out_pixel_d;
  logic            underflow_q, underflow_d;

  // FSM-decoded actions for the current cycle
  logic            skip_pop;
  logic            act_strobe;
  logic            blank;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_data  = mem_q[rd_ptr_q[AW-1:0]];

  // in_ready is forced low while reset is asserted, not just when full
  assign in_ready   = reset_n && !fifo_full;
  assign push       = in_valid && in_ready;
  assign pop        = skip_pop || (act_strobe && !fifo_empty);

  assign out_valid   = out_valid_q;
  assign out_pixel   = out_pixel_q;
  assign underflow   = underflow_q;
  assign line_active = (state_q == ST_SKIP) || (state_q == ST_ACTIVE);

  // FSM state register
  always_ff @(posedge clk30 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: line_start restarts the line from any state
  always_comb begin
    state_d = state_q;
    if (line_start) begin
      if (crop_left != 10'd0) begin
        state_d = ST_SKIP;
      end else if (width != 10'd0) begin
        state_d = ST_ACTIVE;
      end else begin
        state_d = ST_DONE;
      end
    end else begin
      case (state_q)
        ST_SKIP: begin
          if (!fifo_empty && (skip_cnt_q == crop_q - 10'd1)) begin
            state_d = (width_q != 10'd0) ? ST_ACTIVE : ST_DONE;
          end
        end
        ST_ACTIVE: begin
          if (newpixel && (out_cnt_q == width_q - 10'd1)) begin
            state_d = ST_DONE;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // FSM outputs: a coincident line_start suppresses both skipping and output
  always_comb begin
    skip_pop   = 1'b0;
    act_strobe = 1'b0;
    blank      = 1'b0;
    if (!line_start) begin
      case (state_q)
        ST_SKIP:   skip_pop   = !fifo_empty;
        ST_ACTIVE: act_strobe = newpixel;
        default: begin
          skip_pop   = 1'b0;
          act_strobe = 1'b0;
        end
      endcase
    end
    blank = act_strobe && fifo_empty;
  end

  // Next values for pointers, counters and output registers
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    crop_d      = crop_q;
    width_d     = width_q;
    skip_cnt_d  = skip_cnt_q;
    out_cnt_d   = out_cnt_q;
    out_valid_d = act_strobe;
    out_pixel_d = out_pixel_q;
    underflow_d = underflow_q || blank;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    if (line_start) begin
      crop_d     = crop_left;
      width_d    = width;
      skip_cnt_d = 10'd0;
      out_cnt_d  = 10'd0;
    end else begin
      if (skip_pop) begin
        skip_cnt_d = skip_cnt_q + 10'd1;
      end
      if (act_strobe) begin
        out_cnt_d = out_cnt_q + 10'd1;
      end
    end

    if (act_strobe) begin
      out_pixel_d = fifo_empty ? '0 : head_data;
    end
  end

  // Control and datapath registers
  always_ff @(posedge clk30 or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      crop_q      <= 10'd0;
      width_q     <= 10'd0;
      skip_cnt_q  <= 10'd0;
      out_cnt_q   <= 10'd0;
      out_valid_q <= 1'b0;
      out_pixel_q <= '0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      crop_q      <= crop_d;
      width_q     <= width_d;
      skip_cnt_q  <= skip_cnt_d;
      out_cnt_q   <= out_cnt_d;
      out_valid_q <= out_valid_d;
      out_pixel_q <= out_pixel_d;
      underflow_q <= underflow_d;
    end
  end

  // FIFO storage write; contents need no reset since pointers define validity
  always_ff @(posedge clk30) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= in_data;
    end
  end

`ifdef FMV_PIXEL_PACER_STATS_EN
  logic [15:0] uf_cnt_q, uf_cnt_d;

  // Next blank-pixel count, saturating at all-ones
  always_comb begin
    uf_cnt_d = uf_cnt_q;
    if (blank && (uf_cnt_q != 16'hFFFF)) begin
      uf_cnt_d = uf_cnt_q + 16'd1;
    end
  end

  // Blank-pixel counter register
  always_ff @(posedge clk30 or negedge reset_n) begin
    if (!reset_n) begin
      uf_cnt_q <= 16'd0;
    end else begin
      uf_cnt_q <= uf_cnt_d;
    end
  end

  assign underflow_count = uf_cnt_q;
`else
  assign underflow_count = 16'd0;
`endif

endmodule

// File: doc/fmv_pixel_pacer.md
FMV_PIXEL_PACER -- requirements
Module: fmv_pixel_pacer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning pixel FIFO depth in entries (power of two, 4..32).
REQ-002 The block SHALL have parameter PIXW, default 24, meaning pixel data width (YCbCr or RGB, opaque).
REQ-003 The block SHALL have port clk30  in  1  30 MHz system clock, the only clock.
REQ-004 The block SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-005 The block SHALL have port newpixel  in  1  one-cycle pixel-rate strobe from the sample rate converter.
REQ-006 The block SHALL have port line_start  in  1  one-cycle pulse marking the start of a display line.
REQ-007 The block SHALL have port in_valid  in  1  decoder pixel valid.
REQ-008 The block SHALL have port in_data  in  PIXW  decoder pixel.
REQ-009 The block SHALL have port in_ready  out  1  FIFO can accept (high when not full).
REQ-010 The block SHALL have port crop_left  in  10  input pixels discarded at the start of each line.
REQ-011 The block SHALL have port width  in  10  output pixels per line.
REQ-012 The block SHALL have port out_valid  out  1  one-cycle output pixel strobe.
REQ-013 The block SHALL have port out_pixel  out  PIXW  output pixel, held between strobes.
REQ-014 The block SHALL have port line_active  out  1  high while in SKIP or ACTIVE.
REQ-015 The block SHALL have port underflow  out  1  sticky flag, set on any blank-substituted pixel.
REQ-016 The block SHALL have port underflow_count  out  16  count of blank-substituted pixels.

Function
REQ-017 The FIFO SHALL push on in_valid && in_ready and SHALL have in_ready = !full; push and pop in the same cycle SHALL be legal when not full.
REQ-018 The state machine SHALL have states IDLE, SKIP, ACTIVE, DONE.
REQ-019 On line_start in any state, the block SHALL latch crop_left and width, clear both line counters, and enter SKIP if crop_left>0, else ACTIVE if width>0, else DONE.
REQ-020 line_start SHALL NOT flush the FIFO.
REQ-021 In SKIP, the block SHALL pop one entry per cycle whenever the FIFO is non-empty, independent of newpixel, and SHALL enter ACTIVE (or DONE if width=0) on the cycle the crop_left-th entry is popped.
REQ-022 In ACTIVE, on each newpixel the block SHALL pop the head into out_pixel and assert out_valid exactly one cycle later (latency 1).
REQ-023 On a newpixel in ACTIVE with an empty FIFO, the block SHALL output out_pixel=0 with out_valid, set underflow, and count the pixel toward width.
REQ-024 After the width-th output strobe, the block SHALL enter DONE; newpixel in IDLE, SKIP or DONE SHALL produce no out_valid.
REQ-025 A newpixel coincident with line_start SHALL be ignored for output.
REQ-026 In DONE and IDLE, the FIFO SHALL keep accepting input but SHALL NOT pop.
REQ-027 Counters SHALL be 10-bit and SHALL compare against the latched values, so mid-line changes to crop_left or width have no effect until the next line_start.

Reset
REQ-028 On reset_n low, asynchronously: state=IDLE, FIFO empty, counters 0, out_valid=0, out_pixel=0, line_active=0, underflow=0, underflow_count=0.
REQ-029 While reset_n is low, in_ready SHALL be 0.
REQ-030 Deassertion of reset_n mid-line SHALL leave the block in IDLE until the next line_start.

Configuration
REQ-031 With FMV_PIXEL_PACER_STATS_EN defined, underflow_count SHALL increment on each blank-substituted pixel and saturate at 65535.
REQ-032 Without FMV_PIXEL_PACER_STATS_EN, underflow_count SHALL be tied to 0; all other behaviour SHALL be identical.

Verification
REQ-033 The bench SHALL cover: crop_left=7, width=345, input 0..351 always available, newpixel every 2nd cycle -> out_pixel sequence 7..351, 345 strobes, then no strobes until line_start.
REQ-034 The bench SHALL cover: crop_left=0, width=4, FIFO empty, 4 newpixel -> 4 strobes with out_pixel=0, underflow=1, underflow_count=4 (STATS_EN) or 0 (no STATS_EN).
REQ-035 The bench SHALL cover: DEPTH=8, 8 pushes with no pops -> in_ready=0; one pop with in_valid high -> exactly one new entry accepted, no data lost.
REQ-036 The bench SHALL cover: line_start after the 100th output of width=345 -> restart with counters 0, FIFO contents preserved, next output is the head entry.
REQ-037 The bench SHALL cover: reset_n pulsed low mid-ACTIVE -> all outputs 0 immediately, no out_valid until line_start plus newpixel.
REQ-038 The bench SHALL cover: width=0 with line_start -> DONE, no strobes, line_active=0.
